// File: rtl/drive_pkg.sv
// drive_pkg: shared types and constants for the line-follower drive block.
//   drive_state_t : wheel-pair sequencer states
//   DIR_*_FWD     : forward direction bit per wheel (mirrored mounting)
//   COUNT_W       : width of the PWM timebase
//   SENS_*        : sensor codes, ordered {left, middle, right}, 1 = black
//   sensor_map()  : steering decision for every code except line-lost
package drive_pkg;

   localparam int unsigned COUNT_W = 17;

   localparam logic DIR_L_FWD = 1'b0;
   localparam logic DIR_R_FWD = 1'b1;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      FORWARD      = 3'd1,
      GENTLE_LEFT  = 3'd2,
      SHARP_LEFT   = 3'd3,
      GENTLE_RIGHT = 3'd4,
      SHARP_RIGHT  = 3'd5,
      STOPPED      = 3'd6
   } drive_state_t;

   localparam logic [2:0] SENS_LOST   = 3'b000;
   localparam logic [2:0] SENS_CENTER = 3'b010;
   localparam logic [2:0] SENS_ALL    = 3'b111;
   localparam logic [2:0] SENS_SPLIT  = 3'b101;
   localparam logic [2:0] SENS_GL     = 3'b110;
   localparam logic [2:0] SENS_SL     = 3'b100;
   localparam logic [2:0] SENS_GR     = 3'b011;
   localparam logic [2:0] SENS_SR     = 3'b001;

   // Line-lost (000) is handled by the caller; it maps to FORWARD here.
   function automatic drive_state_t sensor_map(input logic [2:0] code);
      drive_state_t s;
      case (code)
         SENS_GL: s = GENTLE_LEFT;
         SENS_SL: s = SHARP_LEFT;
         SENS_GR: s = GENTLE_RIGHT;
         SENS_SR: s = SHARP_RIGHT;
         default: s = FORWARD;   // 010, 111, 101
      endcase
      return s;
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: free-running PWM frame counter, 0 .. PERIOD-1.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   count_out   : current timebase value
//   period_tick : high while count_out == PERIOD-1 (decoded from the register)
module pwm_timebase
   import drive_pkg::*;
#(
   parameter int unsigned PERIOD = 100000
) (
   input  logic               clk,
   input  logic               reset,
   output logic [COUNT_W-1:0] count_out,
   output logic               period_tick
);

   localparam logic [COUNT_W-1:0] LAST = COUNT_W'(PERIOD - 1);

   logic [COUNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = (count_q == LAST) ? '0 : count_q + COUNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

   assign count_out   = count_q;
   assign period_tick = (count_q == LAST);

endmodule

// File: rtl/drive_controller.sv
// drive_controller: sequencer for the two wheel motors of the line follower.
//   clk, reset           : system clock, asynchronous active-low reset
//   start                : start request, a single-cycle pulse is latched
//   sensor_l/_m/_r       : asynchronous line sensors, 1 = black line seen
//   count_out            : shared PWM timebase for both motorcontrol blocks
//   period_tick          : high on the last cycle of each PWM frame
//   motor_l/r_reset      : 1 = motor held off
//   motor_l/r_direction  : wheel direction (held while the motor is off)
// Sensors are sampled once per frame; all motor outputs change on the edge
// where the timebase wraps, so a PWM pulse is never cut short.
module drive_controller
   import drive_pkg::*;
#(
   parameter int unsigned PERIOD       = 100000,
   parameter int unsigned LOST_PERIODS = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               sensor_l,
   input  logic               sensor_m,
   input  logic               sensor_r,
   output logic [COUNT_W-1:0] count_out,
   output logic               period_tick,
   output logic               motor_l_reset,
   output logic               motor_l_direction,
   output logic               motor_r_reset,
   output logic               motor_r_direction
);

   localparam int unsigned LOST_W = $clog2(LOST_PERIODS + 1);

   logic [2:0]        sync1_q, sync2_q;
   logic              start_q, start_d, start_eff;
   drive_state_t      state_q, state_d;
   logic [LOST_W-1:0] lost_q, lost_d, lost_inc;
   logic              l_rst_q, l_rst_d, l_dir_q, l_dir_d;
   logic              r_rst_q, r_rst_d, r_dir_q, r_dir_d;

   pwm_timebase #(.PERIOD(PERIOD)) u_timebase (
      .clk         (clk),
      .reset       (reset),
      .count_out   (count_out),
      .period_tick (period_tick)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {sensor_l, sensor_m, sensor_r};
         sync2_q <= sync1_q;
      end
   end

   // A start arriving in the tick cycle itself is consumed by that tick.
   assign start_eff = start_q | start;

   // Saturating increment keeps the lost counter from wrapping.
   assign lost_inc = (lost_q == '1) ? lost_q : lost_q + LOST_W'(1);

   always_comb begin
      start_d = period_tick ? 1'b0 : start_eff;
      state_d = state_q;
      lost_d  = lost_q;
      l_rst_d = l_rst_q;
      l_dir_d = l_dir_q;
      r_rst_d = r_rst_q;
      r_dir_d = r_dir_q;

      if (period_tick) begin
         case (state_q)
            IDLE, STOPPED: begin
               if (start_eff) begin
                  if (sync2_q == SENS_LOST) begin
                     state_d = FORWARD;
                     lost_d  = LOST_W'(1);
                  end else begin
                     state_d = sensor_map(sync2_q);
                     lost_d  = '0;
                  end
               end
            end
            default: begin
               if (sync2_q == SENS_LOST) begin
                  if (32'(lost_inc) >= LOST_PERIODS) begin
                     state_d = STOPPED;
                     lost_d  = '0;
                  end else begin
                     lost_d  = lost_inc;
                  end
               end else begin
                  state_d = sensor_map(sync2_q);
                  lost_d  = '0;
               end
            end
         endcase

         // Motor settings follow the state being entered; a wheel that is
         // switched off keeps its last direction.
         case (state_d)
            FORWARD: begin
               l_rst_d = 1'b0; l_dir_d = DIR_L_FWD;
               r_rst_d = 1'b0; r_dir_d = DIR_R_FWD;
            end
            GENTLE_LEFT: begin
               l_rst_d = 1'b1;
               r_rst_d = 1'b0; r_dir_d = DIR_R_FWD;
            end
            SHARP_LEFT: begin
               l_rst_d = 1'b0; l_dir_d = ~DIR_L_FWD;
               r_rst_d = 1'b0; r_dir_d = DIR_R_FWD;
            end
            GENTLE_RIGHT: begin
               l_rst_d = 1'b0; l_dir_d = DIR_L_FWD;
               r_rst_d = 1'b1;
            end
            SHARP_RIGHT: begin
               l_rst_d = 1'b0; l_dir_d = DIR_L_FWD;
               r_rst_d = 1'b0; r_dir_d = ~DIR_R_FWD;
            end
            default: begin
               l_rst_d = 1'b1;
               r_rst_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_q <= 1'b0;
         state_q <= IDLE;
         lost_q  <= '0;
         l_rst_q <= 1'b1;
         l_dir_q <= 1'b0;
         r_rst_q <= 1'b1;
         r_dir_q <= 1'b0;
      end else begin
         start_q <= start_d;
         state_q <= state_d;
         lost_q  <= lost_d;
         l_rst_q <= l_rst_d;
         l_dir_q <= l_dir_d;
         r_rst_q <= r_rst_d;
         r_dir_q <= r_dir_d;
      end
   end

   assign motor_l_reset     = l_rst_q;
   assign motor_l_direction = l_dir_q;
   assign motor_r_reset     = r_rst_q;
   assign motor_r_direction = r_dir_q;

endmodule
